// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin arbiter: FSM state encoding,
// default sizing and a one-hot to index encoder.
package arb_pkg;

    localparam int unsigned DEF_NUM_REQ  = 4;
    localparam int unsigned DEF_MAX_HOLD = 8;

    // Widest requester vector the encoder below supports
    localparam int unsigned MAX_REQ   = 16;
    localparam int unsigned MAX_IDX_W = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    // Index of the set bit of a one-hot (or zero) vector; zero input gives 0
    function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        logic [MAX_IDX_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) begin
                idx = idx | MAX_IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first eligible requester strictly after
// last_ptr, with wrap-around; done as rotate, lowest-bit isolate, un-rotate.
module rr_pick
    import arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_ptr,
    input  logic [NUM_REQ-1:0] exclude,
    output logic               found,
    output logic [ID_W-1:0]    pick
);

    // One extra bit so index sums up to 2*NUM_REQ-2 fit before the modulo fold
    localparam int unsigned CNT_W = ID_W + 1;

    logic [NUM_REQ-1:0]   masked;
    logic [NUM_REQ-1:0]   rotated;
    logic [NUM_REQ-1:0]   lowest;
    logic [CNT_W-1:0]     start;
    logic [CNT_W-1:0]     src;
    logic [CNT_W-1:0]     rot_idx;
    logic [CNT_W-1:0]     sum;
    logic [MAX_IDX_W-1:0] enc;

    assign masked = req & ~exclude;
    assign found  = |masked;

    always_comb begin
        start = CNT_W'(last_ptr) + CNT_W'(1);
        if (start >= CNT_W'(NUM_REQ)) begin
            start = start - CNT_W'(NUM_REQ);
        end
    end

    // rotated[0] is the requester right after last_ptr
    always_comb begin
        rotated = '0;
        src     = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            src = start + CNT_W'(i);
            if (src >= CNT_W'(NUM_REQ)) begin
                src = src - CNT_W'(NUM_REQ);
            end
            rotated[i] = masked[ID_W'(src)];
        end
    end

    assign lowest  = rotated & (~rotated + NUM_REQ'(1));
    assign enc     = onehot_to_idx(MAX_REQ'(lowest));
    assign rot_idx = CNT_W'(enc);

    always_comb begin
        sum = start + rot_idx;
        if (sum >= CNT_W'(NUM_REQ)) begin
            sum = sum - CNT_W'(NUM_REQ);
        end
        pick = ID_W'(sum);
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with hold and timeout: registered one-hot grant that
// stays with its owner while requested, rotating after MAX_HOLD under contention.
module rr_arbiter
    import arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ  = DEF_NUM_REQ,
    parameter  int unsigned MAX_HOLD = DEF_MAX_HOLD,
    parameter  int unsigned ID_W     = $clog2(NUM_REQ),
    localparam int unsigned HC_W     = $clog2(MAX_HOLD + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic               grant_valid,
    output logic [ID_W-1:0]    grant_id,
    output logic [HC_W-1:0]    hold_cnt
);

    state_e             state_q;
    state_e             state_d;
    logic [ID_W-1:0]    last_ptr;
    logic [ID_W-1:0]    ptr_d;
    logic [NUM_REQ-1:0] grant_d;
    logic [ID_W-1:0]    id_d;
    logic [HC_W-1:0]    hold_d;
    logic               valid_d;

    logic               owner_req;
    logic               others_req;
    logic               hold_max;
    logic               take;
    logic               pick_found;
    logic [ID_W-1:0]    pick_idx;

    assign owner_req  = |(req & grant);
    assign others_req = |(req & ~grant);
    assign hold_max   = (hold_cnt == HC_W'(MAX_HOLD));

    // Current owner is masked out so a timeout always moves to someone else
    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req      (req),
        .last_ptr (last_ptr),
        .exclude  (grant),
        .found    (pick_found),
        .pick     (pick_idx)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            last_ptr    <= ID_W'(NUM_REQ - 1);
            grant       <= '0;
            grant_id    <= '0;
            hold_cnt    <= '0;
            grant_valid <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_ptr    <= ptr_d;
            grant       <= grant_d;
            grant_id    <= id_d;
            hold_cnt    <= hold_d;
            grant_valid <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = last_ptr;
        grant_d = grant;
        id_d    = grant_id;
        hold_d  = hold_cnt;
        take    = 1'b0;

        case (state_q)
            IDLE: begin
                take = pick_found;
            end
            BUSY: begin
                if (owner_req) begin
                    if (others_req && hold_max) begin
                        take = 1'b1;
                    end else if (!hold_max) begin
                        hold_d = hold_cnt + HC_W'(1);
                    end
                end else if (pick_found) begin
                    take = 1'b1;
                end else begin
                    state_d = IDLE;
                    grant_d = '0;
                    id_d    = '0;
                    hold_d  = '0;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                id_d    = '0;
                hold_d  = '0;
            end
        endcase

        // Hand-over goes straight to the new owner, no idle bubble
        if (take) begin
            state_d = BUSY;
            grant_d = NUM_REQ'(1) << pick_idx;
            id_d    = pick_idx;
            ptr_d   = pick_idx;
            hold_d  = HC_W'(1);
        end

        valid_d = |grant_d;
    end

endmodule

// File: tb/tb_rr_arbiter.sv
// Bench for rr_arbiter: reference model feeds a scoreboard each cycle, plus
// directed constant checks for rotation, hold, release, idle fairness and reset.
module tb_rr_arbiter;

    localparam int N     = 4;
    localparam int MH    = 8;
    localparam int IDW   = 2;
    localparam int HCW   = 4;
    localparam int BOUND = (N - 1) * MH + 1;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [N-1:0]   grant;
    logic           grant_valid;
    logic [IDW-1:0] grant_id;
    logic [HCW-1:0] hold_cnt;

    logic [1:0]     req2;
    logic [1:0]     grant2;
    logic           grant_valid2;
    logic           grant_id2;
    logic           hold_cnt2;

    rr_arbiter #(.NUM_REQ(N), .MAX_HOLD(MH)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .hold_cnt    (hold_cnt)
    );

    rr_arbiter #(.NUM_REQ(2), .MAX_HOLD(1)) dut2 (
        .clk         (clk),
        .reset       (reset),
        .req         (req2),
        .grant       (grant2),
        .grant_valid (grant_valid2),
        .grant_id    (grant_id2),
        .hold_cnt    (hold_cnt2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]   g;
        logic [IDW-1:0] id;
        logic [HCW-1:0] h;
    } exp_t;

    exp_t sb_q[$];

    int errors = 0;
    int checks = 0;
    int max_wait = 0;
    int wait_cnt[N];

    bit m_busy;
    int m_own;
    int m_ptr;
    int m_hold;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int search(input logic [N-1:0] r, input int ptr, input int excl);
        for (int i = 1; i <= N; i++) begin
            int c;
            c = (ptr + i) % N;
            if (r[c] && c != excl) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy = 1'b0;
        m_own  = 0;
        m_ptr  = N - 1;
        m_hold = 0;
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    endtask

    task automatic model_step(input logic [N-1:0] r);
        int   p;
        exp_t e;
        logic [N-1:0] others;
        others = r;
        others[m_own] = 1'b0;
        if (!m_busy) begin
            p = search(r, m_ptr, -1);
            if (p >= 0) begin
                m_busy = 1'b1; m_own = p; m_ptr = p; m_hold = 1;
            end
        end else if (r[m_own]) begin
            if (others == '0 || m_hold < MH) begin
                if (m_hold < MH) m_hold++;
            end else begin
                p = search(r, m_ptr, m_own);
                m_own = p; m_ptr = p; m_hold = 1;
            end
        end else begin
            p = search(r, m_ptr, -1);
            if (p >= 0) begin
                m_own = p; m_ptr = p; m_hold = 1;
            end else begin
                m_busy = 1'b0; m_own = 0; m_hold = 0;
            end
        end
        e.g = '0;
        if (m_busy) e.g[m_own] = 1'b1;
        e.id = m_busy ? IDW'(m_own) : '0;
        e.h  = HCW'(m_hold);
        sb_q.push_back(e);
    endtask

    // Drive one cycle of requests, then compare against the scoreboard head
    task automatic step(input logic [N-1:0] r);
        exp_t e;
        req = r;
        model_step(r);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 32'(sb_q.size()), 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk("grant", 32'(grant), 32'(e.g));
            chk("grant_id", 32'(grant_id), 32'(e.id));
            chk("hold_cnt", 32'(hold_cnt), 32'(e.h));
            chk("grant_valid", 32'(grant_valid), 32'(|e.g));
        end
        chk("onehot0", 32'($onehot0(grant)), 32'd1);
        for (int i = 0; i < N; i++) begin
            if (req[i] && !grant[i]) wait_cnt[i]++;
            else wait_cnt[i] = 0;
            if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
        end
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        req   = '0;
        req2  = '0;
        model_reset();
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_valid", 32'(grant_valid), 32'd0);
        chk("rst_id", 32'(grant_id), 32'd0);
        chk("rst_hold", 32'(hold_cnt), 32'd0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        logic [N-1:0] r;
        logic [N-1:0] one;
        one = 1;

        apply_reset();

        // Full contention: each owner exactly MH cycles, back to back
        for (int k = 0; k < 40; k++) begin
            step(4'b1111);
            chk("rot_grant", 32'(grant), 32'(one << ((k / MH) % N)));
            chk("rot_hold", 32'(hold_cnt), 32'((k % MH) + 1));
        end

        // Lone requester keeps the grant, hold saturates
        for (int k = 0; k < 20; k++) begin
            step(4'b0100);
            chk("solo_grant", 32'(grant), 32'h4);
            chk("solo_id", 32'(grant_id), 32'd2);
            chk("solo_hold", 32'(hold_cnt), 32'((k + 1 < MH) ? k + 1 : MH));
        end

        // Owner release hands over on the same edge
        repeat (3) step(4'b0011);
        chk("rel_owner0", 32'(grant), 32'h1);
        step(4'b0010);
        chk("rel_grant", 32'(grant), 32'h2);
        chk("rel_hold", 32'(hold_cnt), 32'd1);
        step(4'b0000);
        chk("rel_idle", 32'(grant), 32'h0);
        chk("rel_valid", 32'(grant_valid), 32'd0);

        // Pointer survives idle time
        repeat (4) step(4'b0000);
        step(4'b1111);
        chk("idle_fair", 32'(grant), 32'h4);

        // Async reset between edges
        apply_reset();
        repeat (25) step(4'b1111);
        chk("pre_rst", 32'(grant), 32'h8);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_grant", 32'(grant), 32'd0);
        chk("arst_valid", 32'(grant_valid), 32'd0);
        chk("arst_id", 32'(grant_id), 32'd0);
        chk("arst_hold", 32'(hold_cnt), 32'd0);
        model_reset();
        sb_q.delete();
        @(negedge clk);
        reset = 1'b1;
        step(4'b1001);
        chk("post_rst", 32'(grant), 32'h1);

        // Random bursty traffic against the model
        r = '0;
        for (int k = 0; k < 10000; k++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 7) == 0) r[i] = ~r[i];
            end
            step(r);
        end
        chk("max_wait_ok", 32'(max_wait <= BOUND), 32'd1);

        // Two requesters, MAX_HOLD 1: strict alternation
        req2 = 2'b11;
        for (int k = 0; k < 6; k++) begin
            step(r);
            chk("alt_grant", 32'(grant2), (k % 2 == 0) ? 32'h1 : 32'h2);
            chk("alt_hold", 32'(hold_cnt2), 32'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
